// File: rtl/match_event_fifo_if.sv
// ---------------------------------------------------------------------------
// match_event_fifo_if
// Output stream of match_event_fifo: the head of the event FIFO, drained by
// the host with a valid/ready handshake.
//   out_valid  FIFO head valid        (master -> slave)
//   out_ts     timestamp of the head  (master -> slave)
//   out_ready  host accepts the head  (slave  -> master)
// ---------------------------------------------------------------------------
interface match_event_fifo_if #(
  parameter int TS_W = 16
);
  logic            out_valid;
  logic            out_ready;
  logic [TS_W-1:0] out_ts;

  modport master (output out_valid, output out_ts, input out_ready);
  modport slave  (input out_valid, input out_ts, output out_ready);
endinterface

// File: rtl/match_event_fifo.sv
// ---------------------------------------------------------------------------
// match_event_fifo
// Turns the pattern detector's 1-bit match flag into timestamped events and
// queues them in a DEPTH-entry FIFO that the host drains over valid/ready.
// Also keeps saturating match/drop counters and a sticky overflow flag.
//
// Ports
//   clk          clock
//   resetn       synchronous active-low reset
//   seen         match flag, sampled every cycle
//   edge_only    1: rising edges of seen are events; 0: every seen=1 cycle is
//   ovf_clear    clears overflow and drop_count (a same-cycle drop wins)
//   head         event stream out (out_valid / out_ready / out_ts)
//   match_count  events detected, accepted or dropped, saturating
//   drop_count   events lost to a full FIFO, saturating
//   overflow     sticky: at least one event dropped since last clear
// ---------------------------------------------------------------------------
module match_event_fifo #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                seen,
  input  logic                edge_only,
  input  logic                ovf_clear,
  match_event_fifo_if.master  head,
  output logic [CNT_W-1:0]    match_count,
  output logic [CNT_W-1:0]    drop_count,
  output logic                overflow
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     OCC_FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TS_W-1:0] ts;
  logic            seen_q;

  logic [TS_W-1:0] mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [AW:0]     occ;
  logic [TS_W-1:0] ts_hold;

  logic valid;
  logic event_w;
  logic pop;
  logic full;
  logic accept;
  logic drop;

  // edge_only acts combinationally so a change applies in the same cycle.
  assign event_w = seen & (~edge_only | ~seen_q);

  assign valid  = (occ != '0);
  assign full   = (occ == OCC_FULL);
  assign pop    = valid & head.out_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign accept = event_w & (~full | pop);
  assign drop   = event_w & ~accept;

  assign head.out_valid = valid;
  // When empty, out_ts keeps showing the last head that was presented.
  assign head.out_ts    = valid ? mem[rd_ptr] : ts_hold;

  // Free-running timestamp and previous-seen register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ts     <= '0;
      seen_q <= 1'b0;
    end else begin
      ts     <= ts + TS_W'(1);
      seen_q <= seen;
    end
  end

  // NOTE: the storage array has no reset; occupancy gates every read, so a
  // reset only needs to clear the pointers, which keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (resetn && accept) begin
      mem[wr_ptr] <= ts;
    end
  end

  // Pointers, occupancy and the held output timestamp.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      occ     <= '0;
      ts_hold <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (valid) begin
        ts_hold <= mem[rd_ptr];
      end
      case ({accept, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Status counters. A drop coinciding with ovf_clear restarts the count at 1.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      match_count <= '0;
      drop_count  <= '0;
      overflow    <= 1'b0;
    end else begin
      if (event_w && match_count != CNT_MAX) begin
        match_count <= match_count + CNT_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (ovf_clear) begin
          drop_count <= CNT_W'(1);
        end else if (drop_count != CNT_MAX) begin
          drop_count <= drop_count + CNT_W'(1);
        end
      end else if (ovf_clear) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end

endmodule

// File: doc/match_event_fifo.md
Name: match_event_fifo

Overview:
- Downstream consumer of the serial pattern detector's 1-bit `seen` match flag.
- Converts match cycles into timestamped events and queues them in a small FIFO.
- The host drains the FIFO through a valid/ready interface.
- Also keeps a total-match count, a drop count and a sticky overflow flag for status readout.

Parameters:
TS_W, 16, width of free-running cycle timestamp
DEPTH, 4, FIFO entries; power of two, >=2
CNT_W, 8, width of match_count and drop_count (saturating)

Ports:
clk  in  1  clock
resetn  in  1  reset
seen  in  1  match flag from pattern detector, sampled every cycle
edge_only  in  1  1: count only rising edges of seen; 0: every cycle seen=1 is an event
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_ts  out  TS_W  timestamp of head event
match_count  out  CNT_W  total events detected, saturating
drop_count  out  CNT_W  events lost to full FIFO, saturating
overflow  out  1  sticky: at least one event dropped
ovf_clear  in  1  clears overflow and drop_count

Behaviour:
- Reset is synchronous, active-low, on resetn; clock clk. While resetn=0:
  - ts=0, seen_q=0, FIFO empty.
  - out_valid=0, out_ts=0.
  - match_count=0, drop_count=0, overflow=0.
- Timestamp:
  - ts is 0 in the first cycle with resetn=1 and increments by 1 every cycle.
  - ts wraps modulo 2^TS_W with no flag.
- Event detection, evaluated each cycle with resetn=1:
  - edge_only=0: event = seen.
  - edge_only=1: event = seen & ~seen_q.
  - seen_q is a register holding the previous cycle's seen.
  - edge_only may change at any time and takes effect in the same cycle.
- Event capture:
  - The value written is the ts of the cycle in which the event is sampled.
  - Registered: an event in cycle N appears at the head no earlier than N+1. Into an empty FIFO, out_valid=1 in N+1.
- Pop: occurs when out_valid & out_ready. The head advances at the clock edge.
- out_valid/out_ts rules:
  - out_valid=1 iff FIFO is non-empty.
  - out_ts is the head entry whenever out_valid=1; it holds the last value otherwise.
  - out_ts is stable while out_valid=1 and out_ready=0.
- Push accept: when event=1 and either occupancy<DEPTH, or occupancy==DEPTH with a pop in the same cycle.
  - Full with simultaneous pop: push accepted, occupancy stays DEPTH.
  - Empty with event and out_ready=1: no bypass; the entry appears next cycle.
- Drop: when event=1 and no accept.
  - overflow<=1.
  - drop_count increments, saturating at 2^CNT_W-1.
  - The FIFO is unchanged.
- match_count increments on every event, accepted or dropped, saturating at 2^CNT_W-1.
- ovf_clear=1: overflow<=0 and drop_count<=0, unless a drop occurs in the same cycle.
  - In that case the drop wins: overflow=1, drop_count=1.
  - ovf_clear does not affect match_count or the FIFO.
- Pointers: rd/wr pointers are log2(DEPTH) bits, wrapping naturally. Occupancy counter has log2(DEPTH)+1 bits.
- Reset mid-operation: every element returns to its reset value on the next edge. Queued entries are discarded and nothing is popped.
- Target implementation: 150-250 lines of RTL.

Test Plan:
- Release reset; seen=1 at ts=7, out_ready=0 -> out_valid=1 from ts=8, out_ts=7, match_count=1. Assert out_ready one cycle -> out_valid=0 next cycle.
- edge_only=0, seen high for ts=10..12 -> three entries 10,11,12 popped in order; match_count=3. Repeat with edge_only=1 -> single entry 10 (match_count +1).
- DEPTH=4, out_ready=0, events at ts=20..25 -> FIFO holds 20..23; drop_count=2, overflow=1, match_count=6. Drain -> 20,21,22,23, then out_valid=0.
- FIFO full, event and pop in the same cycle at ts=30 -> no drop, occupancy stays 4, 30 is the last entry.
- ovf_clear=1 alone -> overflow=0, drop_count=0. ovf_clear=1 coincident with a drop -> overflow=1, drop_count=1.
- CNT_W=8, seen held 1 with edge_only=0 for 300 cycles -> match_count=255 (saturated). Then resetn=0 for one cycle mid-stream -> all outputs 0 and ts restarts at 0.
